adc_capture_ctrl: RTL

Sequences ADC sample writes into the capture buffer that the SPI ADC-buffer reader drains: arm, pre-trigger fill, trigger search, post-trigger fill, done.
- Sits between the ADC sample stream and the dual-port capture RAM write port.
- Configured from the 32-bit ADC config word.
- Reports the trigger address and capture status back to the SPI status word.

---
 rtl/adc_capture_ctrl_if.sv | 22 ++
 rtl/adc_capture_ctrl.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/adc_capture_ctrl_if.sv
// Sample-stream input and capture-RAM write port of the ADC capture controller.
// The controller connects through the slave modport and the sample source through the master modport.
interface adc_capture_ctrl_if #(
  parameter int AW = 11,
  parameter int DW = 16
);
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (
    output sample_valid, sample_data,
    input  wr_en, wr_addr, wr_data
  );

  modport slave (
    input  sample_valid, sample_data,
    output wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/adc_capture_ctrl.sv
// ADC capture sequencer: arm, pre-trigger fill, trigger search, post-trigger fill, done.
// Writes accepted samples into a circular capture buffer and reports the trigger address.
module adc_capture_ctrl #(
  parameter int AW      = 11,
  parameter int DW      = 16,
  parameter int AUTO_TO = 65535
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          cfg,
  input  logic                 arm,
  input  logic                 abort,
  adc_capture_ctrl_if.slave    bus,
  output logic [AW-1:0]        trig_addr,
  output logic [2:0]           state,
  output logic                 triggered,
  output logic                 done
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRETRIG   = 3'd1,
    WAIT_TRIG = 3'd2,
    POSTTRIG  = 3'd3,
    DONE      = 3'd4
  } state_t;

  localparam int          ACW   = $clog2(AUTO_TO + 1);
  localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

  state_t          state_q;
  logic [7:0]      lvl_q;
  logic            ch_q;
  logic            fall_q;
  logic [1:0]      mode_q;
  logic [AW-1:0]   pre_q;
  logic [AW:0]     cnt_q;
  logic [ACW-1:0]  auto_q;
  logic [7:0]      prev_q;
  logic            prev_vld_q;
  logic            wr_en_q;
  logic [AW-1:0]   wr_addr_q;
  logic [DW-1:0]   wr_data_q;
  logic [AW-1:0]   trig_addr_q;
  logic            triggered_q;
  logic            done_q;

  logic            capturing;
  logic            accept;
  logic [7:0]      cur_byte;
  logic            edge_hit;
  logic            force_trig;
  logic [AW-1:0]   next_addr;
  logic [AW:0]     cnt_inc;
  logic [AW:0]     post_total;
  logic [AW-1:0]   cfg_pre;
  logic            unused_cfg;

  assign cfg_pre    = cfg[12 +: AW];
  assign unused_cfg = ^cfg[31:12+AW];

  assign capturing  = (state_q == PRETRIG) || (state_q == WAIT_TRIG) || (state_q == POSTTRIG);
  assign accept     = bus.sample_valid && capturing;
  assign cur_byte   = ch_q ? bus.sample_data[15:8] : bus.sample_data[7:0];
  assign edge_hit   = prev_vld_q && (fall_q ? ((prev_q > lvl_q) && (cur_byte <= lvl_q))
                                            : ((prev_q < lvl_q) && (cur_byte >= lvl_q)));
  assign force_trig = (mode_q == 2'd2) || ((mode_q == 2'd1) && (auto_q == ACW'(AUTO_TO)));
  // Address the current accepted sample will land on: the pending write has not yet advanced wr_addr.
  assign next_addr  = wr_en_q ? wr_addr_q + 1'b1 : wr_addr_q;
  assign cnt_inc    = cnt_q + 1'b1;
  assign post_total = DEPTH - {1'b0, pre_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      lvl_q       <= '0;
      ch_q        <= 1'b0;
      fall_q      <= 1'b0;
      mode_q      <= '0;
      pre_q       <= '0;
      cnt_q       <= '0;
      auto_q      <= '0;
      prev_q      <= '0;
      prev_vld_q  <= 1'b0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      trig_addr_q <= '0;
      triggered_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= next_addr;
      if (abort) begin
        state_q <= IDLE;
        done_q  <= 1'b0;
      end else if (arm) begin
        lvl_q       <= cfg[7:0];
        ch_q        <= cfg[8];
        fall_q      <= cfg[9];
        mode_q      <= cfg[11:10];
        pre_q       <= cfg_pre;
        cnt_q       <= '0;
        auto_q      <= '0;
        prev_vld_q  <= 1'b0;
        wr_addr_q   <= '0;
        triggered_q <= 1'b0;
        done_q      <= 1'b0;
        state_q     <= (cfg_pre == '0) ? WAIT_TRIG : PRETRIG;
      end else if (accept) begin
        wr_en_q    <= 1'b1;
        wr_data_q  <= bus.sample_data;
        prev_q     <= cur_byte;
        prev_vld_q <= 1'b1;
        case (state_q)
          PRETRIG: begin
            if (cnt_inc == {1'b0, pre_q}) begin
              state_q <= WAIT_TRIG;
              cnt_q   <= '0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          WAIT_TRIG: begin
            if (edge_hit || force_trig) begin
              trig_addr_q <= next_addr;
              triggered_q <= edge_hit;
              // The trigger sample is post-trigger sample 1 and may also be the last one.
              if (post_total == (AW+1)'(1)) begin
                state_q <= DONE;
                done_q  <= 1'b1;
              end else begin
                state_q <= POSTTRIG;
                cnt_q   <= (AW+1)'(1);
              end
            end else if (auto_q != ACW'(AUTO_TO)) begin
              auto_q <= auto_q + 1'b1;
            end
          end
          POSTTRIG: begin
            if (cnt_inc == post_total) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  assign trig_addr   = trig_addr_q;
  assign state       = state_q;
  assign triggered   = triggered_q;
  assign done        = done_q;

endmodule
